// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU control decoder and the iterative M-extension unit.
package alu_pkg;

  // Instruction class handed over by the main decoder.
  typedef enum logic [1:0] {
    ALUOP_LDST   = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_t;

  // ALU operation selects: {fun7[5], fun3}.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // RV32M fun3 encodings.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Sequencer states; the encoding is also exported on the debug port.
  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic f3_signed_a(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV and REM.
  function automatic logic f3_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Radix-2 multiply/divide datapath: operand capture, shared 2*XLEN accumulator,
// iteration counter and final sign fix-up. Sequencing comes from alu_mdu_ctrl.
module mdu_iter_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_done,
  input  logic [2:0]      i_fun3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_count_last,
  output logic            o_special,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN + 1);

  logic [2:0]        r_fun3;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_special;
  logic [XLEN-1:0]   r_special_val;
  logic [CW-1:0]     r_count;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN-1:0]   w_special_val;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_sel;

  // Operand magnitudes and special-case detection on the raw (uncaptured) operands.
  always_comb begin
    w_a_neg = f3_signed_a(i_fun3) & i_rs1[XLEN-1];
    w_b_neg = f3_signed_b(i_fun3) & i_rs2[XLEN-1];
    w_a_mag = w_a_neg ? (~i_rs1 + 1'b1) : i_rs1;
    w_b_mag = w_b_neg ? (~i_rs2 + 1'b1) : i_rs2;
    w_div0  = i_fun3[2] & (i_rs2 == '0);
    w_ovf   = ((i_fun3 == F3_DIV) || (i_fun3 == F3_REM)) &&
              (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
    w_special_val = '0;
    if (w_div0)
      w_special_val = i_fun3[1] ? i_rs1 : '1;
    else if (w_ovf)
      w_special_val = i_fun3[1] ? '0 : i_rs1;
    o_special = w_div0 | w_ovf;
  end

  // One iteration: multiply adds r_b into the high half when the current
  // multiplier bit is set, then shifts right; divide shifts left and does a
  // restoring subtract, feeding the quotient bit into the low half.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    w_shift    = r_acc[2*XLEN-1:XLEN-1];
    w_ge       = (w_shift >= {1'b0, r_b});
    w_sub      = w_shift[XLEN-1:0] - r_b;
    w_div_next = w_ge ? {w_sub, r_acc[XLEN-2:0], 1'b1}
                      : {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
  end

  // Operand capture, iteration and counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fun3        <= '0;
      r_b           <= '0;
      r_acc         <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_special     <= 1'b0;
      r_special_val <= '0;
      r_count       <= '0;
    end else if (i_load) begin
      r_fun3        <= i_fun3;
      r_b           <= w_b_mag;
      r_acc         <= {{XLEN{1'b0}}, w_a_mag};
      r_neg_q       <= w_a_neg ^ w_b_neg;
      r_neg_r       <= w_a_neg;
      r_special     <= o_special;
      r_special_val <= w_special_val;
      r_count       <= CW'(XLEN);
    end else if (i_step) begin
      r_acc   <= r_fun3[2] ? w_div_next : w_mul_next;
      r_count <= r_count - CW'(1);
    end
  end

  // Sign fix-up and result select; the output is zero outside the done cycle.
  always_comb begin
    w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    w_quo  = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    w_rem  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
    w_sel  = '0;
    case (r_fun3)
      F3_MUL:                       w_sel = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_sel = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_sel = w_quo;
      default:                      w_sel = w_rem;
    endcase
    o_result     = i_done ? (r_special ? r_special_val : w_sel) : '0;
    o_count_last = (r_count == CW'(1));
  end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// ALU control decode plus the RV32M sequencer FSM and pipeline stall.
// Handshake: the core holds valid_i and the instruction fields stable while
// stall is high; mdu_done pulses for one cycle with mdu_result, stall drops in
// that same cycle and the core advances.
module alu_mdu_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit ENABLE_M  = 1'b1,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [6:0]      fun7,
  input  logic [2:0]      fun3,
  input  logic [1:0]      alu_op,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [3:0]      alu_ctrl,
  output logic            mdu_sel,
  output logic            stall,
  output logic [XLEN-1:0] mdu_result,
  output logic            mdu_done,
  output logic [1:0]      dbg_state
);

  mdu_state_t r_state;
  mdu_state_t w_next;
  logic       w_is_md;
  logic       w_load;
  logic       w_step;
  logic       w_count_last;
  logic       w_special;

  // Legacy ALU control decode; shifts keep fun7[5] for immediates too.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op_t'(alu_op))
      ALUOP_LDST:   alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl = ALU_SUB;
      ALUOP_RTYPE:  alu_ctrl = {fun7[5], fun3};
      default:      alu_ctrl = ((fun3 == 3'b001) || (fun3 == 3'b101)) ?
                               {fun7[5], fun3} : {1'b0, fun3};
    endcase
  end

  // M-extension instruction detect and the pipeline-facing strobes.
  always_comb begin
    w_is_md   = ENABLE_M && (alu_op == ALUOP_RTYPE) && (fun7 == FUNCT7_MULDIV);
    mdu_sel   = w_is_md;
    stall     = rst_n & ~flush_i & valid_i & w_is_md & (r_state != MDU_DONE);
    mdu_done  = (r_state == MDU_DONE) & ~flush_i;
    dbg_state = r_state;
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= MDU_IDLE;
    else        r_state <= w_next;
  end

  // Next state and datapath strobes; flush overrides everything.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      MDU_IDLE: begin
        if (valid_i && w_is_md) begin
          w_load = 1'b1;
          w_next = (EARLY_OUT && w_special) ? MDU_DONE : MDU_RUN;
        end
      end
      MDU_RUN: begin
        w_step = 1'b1;
        if (w_count_last) w_next = MDU_DONE;
      end
      MDU_DONE: w_next = MDU_IDLE;
      default:  w_next = MDU_IDLE;
    endcase
    if (flush_i) begin
      w_next = MDU_IDLE;
      w_load = 1'b0;
      w_step = 1'b0;
    end
  end

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_done       (mdu_done),
    .i_fun3       (fun3),
    .i_rs1        (rs1_i),
    .i_rs2        (rs2_i),
    .o_count_last (w_count_last),
    .o_special    (w_special),
    .o_result     (mdu_result)
  );

endmodule

// File: doc/alu_mdu_ctrl.md
Name: alu_mdu_ctrl

Overview:
Parametrised successor to the ALU control decoder for the RISC-V core. It keeps the combinational 4-bit ALU control decode and adds RV32M support. MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU run on an iterative multiply/divide sequencer, which stalls the core until the result is ready. It sits between the main decoder and the ALU/writeback mux.

Parameters:
XLEN, 32, operand/result width (power of 2, >=8)
ENABLE_M, 1, 0 = M-extension disabled: mdu_sel is always 0, stall is always 0, legacy decode only
EARLY_OUT, 1, 1 = divide-by-zero and signed-overflow cases finish without iterating

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
valid_i  in  1  the instruction in decode is real (not a bubble)
flush_i  in  1  abort any in-flight M operation
fun7  in  7  instr[31:25]
fun3  in  3  instr[14:12]
alu_op  in  2  class from main decoder
rs1_i  in  XLEN  operand A
rs2_i  in  XLEN  operand B
alu_ctrl  out  4  ALU operation select
mdu_sel  out  1  writeback takes mdu_result instead of ALU result
stall  out  1  freeze PC and decode register
mdu_result  out  XLEN  M-extension result
mdu_done  out  1  mdu_result valid this cycle

Behaviour:
- alu_ctrl is combinational:
  - alu_op 00 -> 0000
  - alu_op 01 -> 1000
  - alu_op 10 -> {fun7[5], fun3}
  - alu_op 11 -> {fun7[5], fun3} when fun3 is 001 or 101, else {0, fun3}
- is_md = ENABLE_M & alu_op==10 & fun7==0000001. mdu_sel = is_md. alu_ctrl is don't-care when is_md.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on valid_i & is_md & !flush_i. Latches operands, fun3 and sign flags; iteration counter = XLEN.
  - IDLE -> DONE instead when EARLY_OUT and a special case is detected.
  - RUN: one radix-2 step per cycle. Multiply = shift-add on magnitudes into a 2*XLEN accumulator. Divide = restoring subtract on magnitudes. Counter decrements; at 0 -> DONE.
  - DONE: mdu_done=1 and mdu_result driven for exactly one cycle, then -> IDLE.
- stall = valid_i & is_md & state!=DONE.
  - Normal op issued at cycle T: stall high T..T+XLEN, done and stall low at T+XLEN+1.
  - Early-out op: stall high for T only, done at T+1.
- Sign handling:
  - MUL/MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV/REM: both operands signed.
  - Magnitudes are taken at start. The product is negated if the signs differ. The quotient is negated if the signs differ. The remainder takes the dividend's sign.
- Result select:
  - MUL -> low XLEN of product; MULH/MULHSU/MULHU -> high XLEN.
  - DIV/DIVU -> quotient; REM/REMU -> remainder.
- Special cases (identical results whether or not EARLY_OUT is set):
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - DIV with rs1 = 100...0 and rs2 = all ones -> rs1; REM in the same case -> 0.
- flush_i has priority over everything: -> IDLE next cycle, no mdu_done, stall low in the flush cycle.
- Operands are captured at start. rs1_i/rs2_i changes during RUN are ignored.
- An M-op arriving in DONE is not restarted. The core advances on the done cycle, so the next op is seen in IDLE.
- Reset (any time, including mid-RUN):
  - Next state IDLE; mdu_result=0, mdu_done=0, counter=0.
  - stall forced 0 while rst_n=0.

Decomposition:
- Package alu_pkg holds:
  - alu_op_t enum (LDST, BRANCH, RTYPE, ITYPE).
  - ALU control constants (ADD=0000, SUB/BR=1000, SLL=0001, SRL=0101, SRA=1101 …).
  - M fun3 constants (MUL=000 … REMU=111).
  - FUNCT7_MULDIV=0000001.
  - mdu_state_t enum.
- Sub-module mdu_iter_core holds the operand registers, the accumulator/remainder datapath, the counter and sign fix-up. alu_mdu_ctrl keeps the decode, FSM and stall logic.

Test Plan:
- Legacy decode: alu_op=11, fun3=101, fun7=0100000 -> alu_ctrl=1101, mdu_sel=0, stall=0. alu_op=11, fun3=000, fun7=0100000 -> alu_ctrl=0000.
- MUL 7 * 0xFFFFFFFD (-3), XLEN=32 -> stall high 33 cycles, then mdu_done for 1 cycle with 0xFFFFFFEB. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14; REMU -> 2. DIV 0xFFFFFF9C(-100)/7 -> 0xFFFFFFF2; REM -> 0xFFFFFFFE.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF, REM -> 5, done after 1 stall cycle (EARLY_OUT=1). DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Flush at RUN cycle 10 -> IDLE next cycle, mdu_done never asserts. A new MUL issued right after completes correctly.
- rst_n low at RUN cycle 5 -> IDLE, stall=0, mdu_result=0. ENABLE_M=0 with a MUL encoding -> mdu_sel=0, stall=0, alu_ctrl=0000.
